mem_bus_arbiter: RTL and testbench

- Shares the core's single memory bus between the fetch-side (I) and memory-stage-side (D) requesters.
- Bus is the split address/data handshake that produces i_data_ok/d_data_ok for the hazard unit.
- Grants one requester at a time and allows one outstanding transaction; D has fixed priority, with a starvation guard for I.
- Routes each response back to the requester that owns the transaction.

---
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one split address/data memory bus between the fetch side (I) and
//   the memory-stage side (D). One transaction in flight at a time. D wins by
//   fixed priority unless it has taken STARVE_LIMIT grants in a row while I
//   was waiting, in which case I is granted next. Responses are routed back
//   to whichever requester owns the transaction.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   ireq_*                      fetch request in, addr_ok back
//   iresp_*                     fetch response (data_ok + read data)
//   dreq_*                      data request in (addr/write/size/strobe/wdata)
//   dresp_*                     data response (load data or store ack)
//   bus_req/addr/write/size/
//   strobe/wdata                request phase toward the bus
//   bus_addr_ok                 bus accepted the request this cycle
//   bus_data_ok, bus_rdata      bus completes the outstanding transaction
//
// state | meaning
// IDLE  | no transaction; arbitrate between ireq_valid and dreq_valid
// REQ   | owner's request driven on the bus, waiting for bus_addr_ok
// RESP  | request accepted, waiting for bus_data_ok

module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                ireq_addr_ok,
  output logic                iresp_data_ok,
  output logic [DATA_W-1:0]   iresp_data,

  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic                dreq_write,
  input  logic [1:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_wdata,
  output logic                dreq_addr_ok,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,

  output logic                bus_req,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_write,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_strobe,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic          owner;      // 0 = I, 1 = D
  logic [SW-1:0] d_streak;   // consecutive D grants taken while I was waiting

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      d_streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ireq_valid && dreq_valid && d_streak == STREAK_MAX) begin
            owner    <= 1'b0;
            d_streak <= '0;
            state    <= REQ;
          end else if (dreq_valid) begin
            owner <= 1'b1;
            state <= REQ;
            if (ireq_valid) begin
              if (d_streak != STREAK_MAX) d_streak <= d_streak + 1'b1;
            end else begin
              d_streak <= '0;
            end
          end else if (ireq_valid) begin
            owner    <= 1'b0;
            d_streak <= '0;
            state    <= REQ;
          end
        end
        REQ:     if (bus_addr_ok) state <= RESP;
        RESP:    if (bus_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset is synchronous, so the state register can still read REQ/RESP
  // during the first reset cycle; gating with reset keeps every output quiet.
  logic req_act;
  logic resp_act;
  assign req_act  = !reset && (state == REQ);
  assign resp_act = !reset && (state == RESP);

  always_comb begin
    bus_req    = 1'b0;
    bus_addr   = '0;
    bus_write  = 1'b0;
    bus_size   = 2'd0;
    bus_strobe = '0;
    bus_wdata  = '0;
    if (req_act) begin
      bus_req = 1'b1;
      if (owner) begin
        bus_addr   = dreq_addr;
        bus_write  = dreq_write;
        bus_size   = dreq_size;
        bus_strobe = dreq_strobe;
        bus_wdata  = dreq_wdata;
      end else begin
        bus_addr = ireq_addr;
        bus_size = 2'd2;
      end
    end
  end

  assign ireq_addr_ok  = req_act && !owner && bus_addr_ok;
  assign dreq_addr_ok  = req_act &&  owner && bus_addr_ok;

  assign iresp_data_ok = resp_act && !owner && bus_data_ok;
  assign dresp_data_ok = resp_act &&  owner && bus_data_ok;

  assign iresp_data = iresp_data_ok ? bus_rdata : '0;
  assign dresp_data = dresp_data_ok ? bus_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq_valid;
  logic [AW-1:0] ireq_addr;
  logic          ireq_addr_ok;
  logic          iresp_data_ok;
  logic [DW-1:0] iresp_data;
  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic          dreq_write;
  logic [1:0]    dreq_size;
  logic [3:0]    dreq_strobe;
  logic [DW-1:0] dreq_wdata;
  logic          dreq_addr_ok;
  logic          dresp_data_ok;
  logic [DW-1:0] dresp_data;
  logic          bus_req;
  logic [AW-1:0] bus_addr;
  logic          bus_write;
  logic [1:0]    bus_size;
  logic [3:0]    bus_strobe;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dreq_addr_ok(dreq_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write), .bus_size(bus_size),
    .bus_strobe(bus_strobe), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({ireq_addr_ok, iresp_data_ok, dreq_addr_ok, dresp_data_ok,
                            bus_req, bus_write, bus_size, bus_strobe}), 64'd0);
    chk({tag, "_bus"}, {bus_addr, bus_wdata}, 64'd0);
    chk({tag, "_rsp"}, {iresp_data, dresp_data}, 64'd0);
  endtask

  // Waits (bounded) for bus_req, checks the request fields, accepts it one
  // cycle, idles one RESP cycle, then completes with rdata.
  task automatic do_txn(input string tag, input bit exp_d, input logic [31:0] exp_addr,
                        input bit exp_write, input logic [1:0] exp_size,
                        input logic [3:0] exp_strobe, input logic [31:0] exp_wdata,
                        input logic [31:0] rdata, input bit drop);
    int n = 0;
    #1;
    while (!bus_req && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 64'(bus_req), 64'd1);
    if (bus_req) begin
      chk({tag, "_addr"}, 64'(bus_addr), 64'(exp_addr));
      chk({tag, "_wss"}, 64'({bus_write, bus_size, bus_strobe}),
          64'({exp_write, exp_size, exp_strobe}));
      chk({tag, "_wdata"}, 64'(bus_wdata), 64'(exp_wdata));
      bus_addr_ok = 1'b1;
      #1;
      chk({tag, "_aok"}, 64'({ireq_addr_ok, dreq_addr_ok}), 64'({!exp_d, exp_d}));
      chk({tag, "_pre"}, 64'({iresp_data_ok, dresp_data_ok, iresp_data, dresp_data}), 64'd0);
      tick();
      bus_addr_ok = 1'b0;
      if (drop) begin
        if (exp_d) dreq_valid = 1'b0;
        else       ireq_valid = 1'b0;
      end
      #1;
      chk({tag, "_resp_wait"}, 64'({bus_req, ireq_addr_ok, dreq_addr_ok,
                                     iresp_data_ok, dresp_data_ok}), 64'd0);
      tick();
      bus_data_ok = 1'b1;
      bus_rdata   = rdata;
      #1;
      chk({tag, "_dok"}, 64'({iresp_data_ok, dresp_data_ok}), 64'({!exp_d, exp_d}));
      chk({tag, "_data"}, {iresp_data, dresp_data},
          exp_d ? {32'd0, rdata} : {rdata, 32'd0});
      tick();
      bus_data_ok = 1'b0;
      bus_rdata   = JUNK;
      #1;
      chk({tag, "_post"}, 64'({iresp_data_ok, dresp_data_ok, iresp_data, dresp_data}), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    ireq_valid = 0; ireq_addr = '0;
    dreq_valid = 0; dreq_addr = '0; dreq_write = 0; dreq_size = 0;
    dreq_strobe = 0; dreq_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = JUNK;

    tick();
    chk_zero("rst0");
    tick();
    chk_zero("rst1");
    reset = 1'b0;
    tick();
    chk_zero("idle");

    // I-only fetch
    ireq_valid = 1'b1;
    ireq_addr  = 32'hBFC0_0000;
    #1;
    chk("i_same_cycle_req", 64'(bus_req), 64'd0);
    do_txn("ifetch", 1'b0, 32'hBFC0_0000, 1'b0, 2'd2, 4'h0, 32'd0, 32'h2408_0001, 1'b1);

    // simultaneous I and D, D word store goes first
    ireq_valid  = 1'b1;
    ireq_addr   = 32'hBFC0_0004;
    dreq_valid  = 1'b1;
    dreq_addr   = 32'h8000_0010;
    dreq_write  = 1'b1;
    dreq_size   = 2'd2;
    dreq_strobe = 4'hF;
    dreq_wdata  = 32'hDEAD_BEEF;
    do_txn("both_d", 1'b1, 32'h8000_0010, 1'b1, 2'd2, 4'hF, 32'hDEAD_BEEF, 32'h1111_2222, 1'b1);
    do_txn("both_i", 1'b0, 32'hBFC0_0004, 1'b0, 2'd2, 4'h0, 32'd0, 32'h3333_4444, 1'b1);

    // starvation guard: both valid continuously
    ireq_valid  = 1'b1;
    ireq_addr   = 32'hBFC0_0100;
    dreq_valid  = 1'b1;
    dreq_addr   = 32'h8000_0100;
    dreq_write  = 1'b0;
    dreq_size   = 2'd2;
    dreq_strobe = 4'h0;
    dreq_wdata  = 32'd0;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        do_txn($sformatf("starve%0d_i", k), 1'b0, 32'hBFC0_0100, 1'b0, 2'd2, 4'h0, 32'd0,
               32'hA000_0000 + 32'(k), 1'b0);
      else
        do_txn($sformatf("starve%0d_d", k), 1'b1, 32'h8000_0100, 1'b0, 2'd2, 4'h0, 32'd0,
               32'hB000_0000 + 32'(k), 1'b0);
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    tick();

    // addr_ok stall for 5 cycles
    dreq_valid  = 1'b1;
    dreq_addr   = 32'h8000_0020;
    dreq_write  = 1'b1;
    dreq_size   = 2'd1;
    dreq_strobe = 4'h3;
    dreq_wdata  = 32'h0000_CAFE;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_req", k), 64'(bus_req), 64'd1);
      chk($sformatf("stall%0d_addr", k), 64'(bus_addr), 64'h8000_0020);
      chk($sformatf("stall%0d_aok", k), 64'({dreq_addr_ok, ireq_addr_ok}), 64'd0);
      tick();
    end
    do_txn("stall_end", 1'b1, 32'h8000_0020, 1'b1, 2'd1, 4'h3, 32'h0000_CAFE, 32'h7777_8888, 1'b1);

    // reset while in RESP, then a late bus_data_ok
    ireq_valid = 1'b1;
    ireq_addr  = 32'hBFC0_0200;
    tick();
    chk("rr_req", 64'(bus_req), 64'd1);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    ireq_valid  = 1'b0;
    reset       = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h9999_0000;
    #1;
    chk_zero("rr_in_reset");
    tick();
    reset       = 1'b0;
    bus_data_ok = 1'b0;
    tick();
    bus_data_ok = 1'b1;
    #1;
    chk_zero("rr_late_dok");
    tick();
    bus_data_ok = 1'b0;
    bus_rdata   = JUNK;
    #1;
    chk_zero("rr_after");

    // byte load from D
    dreq_valid  = 1'b1;
    dreq_addr   = 32'h8000_0003;
    dreq_write  = 1'b0;
    dreq_size   = 2'd0;
    dreq_strobe = 4'h0;
    dreq_wdata  = 32'd0;
    do_txn("byte_ld", 1'b1, 32'h8000_0003, 1'b0, 2'd0, 4'h0, 32'd0, 32'h0000_00A5, 1'b1);
    tick();
    chk_zero("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
